// File: rtl/gcd_ctrl.sv
// GCD controller: sequences load, compare and subtract steps of an external
// 16-bit subtractive GCD datapath, with iteration limit, abort and error flag.
// Outputs are registered from the next state, so they always match the
// current state exactly (Moore behaviour without decode glitches).
module gcd_ctrl #(
   parameter int MAX_ITER = 1024,
   parameter int CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             lt,
   input  logic             gt,
   input  logic             eq,
   output logic             ldA,
   output logic             ldB,
   output logic             sel_in,
   output logic             sel1,
   output logic             sel2,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      COMPARE = 3'd3,
      SUB_A   = 3'd4,
      SUB_B   = 3'd5,
      DONE    = 3'd6,
      ERR     = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Comparator flags are only trustworthy when exactly one of them is set.
   function automatic logic flags_onehot(input logic [2:0] f);
      return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
   endfunction

   state_t           state_r;
   state_t           fsm_nx_s;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic             ld_a_r;
   logic             ld_b_r;
   logic             sel_in_r;
   logic             sel1_r;
   logic             sel2_r;
   logic             busy_r;
   logic             done_r;
   logic             err_r;
   logic             accept_s;
   logic             sub_step_s;

   // A start is only honoured from IDLE; a subtraction counts unless aborted.
   assign accept_s   = (state_r == IDLE) && start;
   assign sub_step_s = ((state_r == SUB_A) || (state_r == SUB_B)) && !abort;

   // Nominal next-state decision, before abort is considered.
   always_comb begin
      fsm_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               fsm_nx_s = LOAD_A;
            end else begin
               fsm_nx_s = IDLE;
            end
         end
         LOAD_A:  fsm_nx_s = LOAD_B;
         LOAD_B:  fsm_nx_s = COMPARE;
         COMPARE: begin
            if (!flags_onehot({lt, gt, eq})) begin
               fsm_nx_s = ERR;
            end else if (eq) begin
               fsm_nx_s = DONE;
            end else if (cnt_r == MAX_CNT) begin
               fsm_nx_s = ERR;
            end else if (gt) begin
               fsm_nx_s = SUB_A;
            end else begin
               // one-hot and neither eq nor gt leaves lt
               fsm_nx_s = SUB_B;
            end
         end
         SUB_A:   fsm_nx_s = COMPARE;
         SUB_B:   fsm_nx_s = COMPARE;
         DONE:    fsm_nx_s = IDLE;
         ERR:     fsm_nx_s = IDLE;
         default: fsm_nx_s = IDLE;
      endcase
   end

   // Abort overrides every transition out of a non-IDLE state.
   always_comb begin
      state_s = fsm_nx_s;
      if (abort && (state_r != IDLE)) begin
         state_s = IDLE;
      end else begin
         state_s = fsm_nx_s;
      end
   end

   // State register plus per-state outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         ld_a_r   <= 1'b0;
         ld_b_r   <= 1'b0;
         sel_in_r <= 1'b0;
         sel1_r   <= 1'b0;
         sel2_r   <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         ld_a_r   <= (state_s == LOAD_A) || (state_s == SUB_A);
         ld_b_r   <= (state_s == LOAD_B) || (state_s == SUB_B);
         sel_in_r <= (state_s == LOAD_A) || (state_s == LOAD_B);
         sel1_r   <= (state_s == SUB_B);
         sel2_r   <= (state_s == SUB_A);
         busy_r   <= (state_s != IDLE);
         done_r   <= (state_s == DONE);
      end
   end

   // Sticky error flag: cleared by an accepted start, set on entry to ERR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (accept_s) begin
         err_r <= 1'b0;
      end else if (state_s == ERR) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Subtraction counter: cleared on start, saturating at the iteration limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (sub_step_s && (cnt_r != MAX_CNT)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign ldA      = ld_a_r;
   assign ldB      = ld_b_r;
   assign sel_in   = sel_in_r;
   assign sel1     = sel1_r;
   assign sel2     = sel2_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;
   assign iter_cnt = cnt_r;

endmodule
